// File: rtl/rename_pkg.sv
// Shared types for the rename stage.
// decode_struct is the decoded-instruction payload handed from decode to rename.
// Rename reads only the architectural register fields and RegWrite. Every other
// field passes through unchanged.
package rename_pkg;

  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [6:0]    Opcode;
    logic [2:0]    Funct3;
    logic [31:0]   Imm;
    logic [AW-1:0] ARegAddrSrc0;
    logic [AW-1:0] ARegAddrSrc1;
    logic [AW-1:0] ARegAddrDst;
    logic          RegWrite;
  } decode_struct;

endpackage

// File: rtl/rename_stage.sv
// Two-wide register rename stage.
// It maps architectural sources and destinations through a RAT and allocates
// new destinations from a circular free list. Commit releases physical registers
// back into that free list. The renamed bundle is registered, so it appears one
// cycle after acceptance.
//
// Ports:
//   i_clk, i_rst_n            clock and async active-low reset
//   i_valid, i_decode_data    per-slot decoded instruction from decode
//   o_ready                   free count >= 2; the bundle is consumed this cycle
//   i_free_valid, i_free_preg per-slot physical register released by commit
//   o_valid, o_decode_data    registered renamed bundle
//   o_PRegSrc0/1              physical source registers
//   o_PRegDst                 newly allocated destination (0 if none)
//   o_PRegOld                 previous destination mapping (0 if none)
module rename_stage #(
  parameter int unsigned  ARCH_REGS = 32,
  parameter int unsigned  PHYS_REGS = 64,
  localparam int unsigned PW        = $clog2(PHYS_REGS),
  localparam int unsigned FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid       [0:1],
  input  rename_pkg::decode_struct  i_decode_data [0:1],
  output logic                      o_ready,
  input  logic                      i_free_valid  [0:1],
  input  logic [PW-1:0]             i_free_preg   [0:1],
  output logic                      o_valid       [0:1],
  output rename_pkg::decode_struct  o_decode_data [0:1],
  output logic [PW-1:0]             o_PRegSrc0    [0:1],
  output logic [PW-1:0]             o_PRegSrc1    [0:1],
  output logic [PW-1:0]             o_PRegDst     [0:1],
  output logic [PW-1:0]             o_PRegOld     [0:1]
);

  localparam int unsigned HW = $clog2(FL_DEPTH);
  localparam int unsigned CW = $clog2(FL_DEPTH + 1);

  logic [PW-1:0] rat_q [ARCH_REGS];
  logic [PW-1:0] rat_d [ARCH_REGS];
  logic [PW-1:0] fl_q  [FL_DEPTH];
  logic [PW-1:0] fl_d  [FL_DEPTH];
  logic [HW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          ready_d;

  logic          alloc [0:1];
  logic [PW-1:0] pdst  [0:1];
  logic [PW-1:0] psrc0 [0:1];
  logic [PW-1:0] psrc1 [0:1];
  logic [PW-1:0] pold  [0:1];

  // Circular increment of a free-list index.
  function automatic logic [HW-1:0] fl_inc(input logic [HW-1:0] idx);
    return (idx == HW'(FL_DEPTH - 1)) ? '0 : idx + HW'(1);
  endfunction

  // Rename lookup, RAT/free-list next state and release handling.
  always_comb begin
    rat_d    = rat_q;
    fl_d     = fl_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    head_nxt = fl_inc(head_q);

    for (int k = 0; k < 2; k++) begin
      alloc[k] = i_valid[k] & i_decode_data[k].RegWrite &
                 (i_decode_data[k].ARegAddrDst != '0);
    end

    // Slot 1 takes the head entry when slot 0 does not allocate.
    pdst[0] = alloc[0] ? fl_q[head_q] : '0;
    pdst[1] = '0;
    if (alloc[1]) pdst[1] = alloc[0] ? fl_q[head_nxt] : fl_q[head_q];

    psrc0[0] = (i_decode_data[0].ARegAddrSrc0 == '0) ? '0 : rat_q[i_decode_data[0].ARegAddrSrc0];
    psrc1[0] = (i_decode_data[0].ARegAddrSrc1 == '0) ? '0 : rat_q[i_decode_data[0].ARegAddrSrc1];
    pold[0]  = alloc[0] ? rat_q[i_decode_data[0].ARegAddrDst] : '0;

    // Slot 1 sees slot 0's new mapping through the intra-bundle bypass.
    psrc0[1] = (i_decode_data[1].ARegAddrSrc0 == '0) ? '0 : rat_q[i_decode_data[1].ARegAddrSrc0];
    if (alloc[0] && (i_decode_data[1].ARegAddrSrc0 == i_decode_data[0].ARegAddrDst))
      psrc0[1] = pdst[0];
    psrc1[1] = (i_decode_data[1].ARegAddrSrc1 == '0) ? '0 : rat_q[i_decode_data[1].ARegAddrSrc1];
    if (alloc[0] && (i_decode_data[1].ARegAddrSrc1 == i_decode_data[0].ARegAddrDst))
      psrc1[1] = pdst[0];
    pold[1] = '0;
    if (alloc[1]) begin
      pold[1] = (alloc[0] && (i_decode_data[1].ARegAddrDst == i_decode_data[0].ARegAddrDst))
                ? pdst[0] : rat_q[i_decode_data[1].ARegAddrDst];
    end

    // Commit the bundle. Slot 1 is written last, so it wins a WAW.
    if (o_ready) begin
      if (alloc[0]) rat_d[i_decode_data[0].ARegAddrDst] = pdst[0];
      if (alloc[1]) rat_d[i_decode_data[1].ARegAddrDst] = pdst[1];
      if (alloc[0] && alloc[1])      head_d = fl_inc(head_nxt);
      else if (alloc[0] || alloc[1]) head_d = head_nxt;
      count_d = count_q - CW'(alloc[0]) - CW'(alloc[1]);
    end

    // Releases push at the tail, slot 0 first. p0 is never released, and a push into a full list is dropped.
    for (int k = 0; k < 2; k++) begin
      if (i_free_valid[k] && (i_free_preg[k] != '0) && (count_d < CW'(FL_DEPTH))) begin
        fl_d[tail_d] = i_free_preg[k];
        tail_d       = fl_inc(tail_d);
        count_d      = count_d + CW'(1);
      end
    end

    ready_d = (count_d >= CW'(2));
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++)  fl_q[i]  <= PW'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FL_DEPTH);
      o_ready <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        o_valid[k]       <= 1'b0;
        o_decode_data[k] <= '0;
        o_PRegSrc0[k]    <= '0;
        o_PRegSrc1[k]    <= '0;
        o_PRegDst[k]     <= '0;
        o_PRegOld[k]     <= '0;
      end
    end else begin
      rat_q   <= rat_d;
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      o_ready <= ready_d;
      for (int k = 0; k < 2; k++) begin
        o_valid[k]       <= i_valid[k] & o_ready;
        o_decode_data[k] <= i_decode_data[k];
        o_PRegSrc0[k]    <= psrc0[k];
        o_PRegSrc1[k]    <= psrc1[k];
        o_PRegDst[k]     <= o_ready ? pdst[k] : '0;
        o_PRegOld[k]     <= o_ready ? pold[k] : '0;
      end
    end
  end

endmodule
